// File: rtl/instr_sequencer_if.sv
// Control, program-memory and instruction-issue signals of the fetch/issue stage.
interface instr_sequencer_if;
  logic        run;
  logic        single_step;
  logic        step;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic        jump;
  logic [7:0]  jump_target;
  logic [7:0]  oper;
  logic [7:0]  addr1;
  logic [7:0]  addr2;
  logic [7:0]  addr3;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        halted;
  logic        fault;

  modport master (
    input  run, single_step, step, mem_data, jump, jump_target,
    output mem_rd, mem_addr, oper, addr1, addr2, addr3, instr_valid, pc, halted, fault
  );

  modport slave (
    output run, single_step, step, mem_data, jump, jump_target,
    input  mem_rd, mem_addr, oper, addr1, addr2, addr3, instr_valid, pc, halted, fault
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/issue stage: reads program words, splits them into oper/addr1..3 and advances pc
// on a divided tick or a step press, following processor jumps and halting after LAST_PC.
module instr_sequencer #(
  parameter int unsigned TICK_DIV = 2000000,
  parameter logic [7:0]  LAST_PC  = 8'd127
) (
  input logic               clk,
  input logic               rst,
  instr_sequencer_if.master bus
);

  localparam int unsigned    CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_t;

  state_t        state_q;
  logic [7:0]    pc_q;
  logic [31:0]   instr_q;
  logic [CW-1:0] tick_q;
  logic          step_q;
  logic          mem_rd_q;
  logic          instr_valid_q;
  logic          halted_q;
  logic          fault_q;

  logic          step_rise;
  logic          advance;

  assign step_rise = bus.step & ~step_q;
  // Counter runs in step mode too; only the selected source can advance.
  assign advance   = bus.single_step ? step_rise : (tick_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      tick_q        <= '0;
      step_q        <= 1'b0;
      mem_rd_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      step_q        <= bus.step;
      mem_rd_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      if (!bus.run) begin
        state_q  <= S_IDLE;
        pc_q     <= '0;
        instr_q  <= '0;
        tick_q   <= '0;
        halted_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q  <= S_FETCH;
            mem_rd_q <= 1'b1;
          end
          S_FETCH: state_q <= S_WAIT;
          S_WAIT: begin
            instr_q       <= bus.mem_data;
            tick_q        <= '0;
            instr_valid_q <= 1'b1;
            state_q       <= S_EXEC;
          end
          S_EXEC: begin
            tick_q <= tick_q + 1'b1;
            if (advance) begin
              if (bus.jump && (bus.jump_target > LAST_PC)) begin
                fault_q  <= 1'b1;
                halted_q <= 1'b1;
                state_q  <= S_HALT;
              end else if (bus.jump) begin
                pc_q     <= bus.jump_target;
                mem_rd_q <= 1'b1;
                state_q  <= S_FETCH;
              end else if (pc_q == LAST_PC) begin
                // Halting here is what keeps pc from ever wrapping past LAST_PC.
                halted_q <= 1'b1;
                state_q  <= S_HALT;
              end else begin
                pc_q     <= pc_q + 8'd1;
                mem_rd_q <= 1'b1;
                state_q  <= S_FETCH;
              end
            end
          end
          S_HALT: state_q <= S_HALT;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_addr    = pc_q;
  assign bus.oper        = instr_q[31:24];
  assign bus.addr1       = instr_q[23:16];
  assign bus.addr2       = instr_q[15:8];
  assign bus.addr3       = instr_q[7:0];
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed/randomised bench for instr_sequencer with a program-level reference model.
module tb_instr_sequencer;

  localparam int         TD   = 4;
  localparam logic [7:0] LAST = 8'd10;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] prog [256];

  instr_sequencer_if bus ();

  instr_sequencer #(.TICK_DIV(TD), .LAST_PC(LAST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Program memory with one cycle of read latency.
  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= prog[bus.mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_out();
    return {bus.oper, bus.addr1, bus.addr2, bus.addr3};
  endfunction

  task automatic wait_valid(input int budget, output bit seen, output int waited);
    seen = 1'b0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      waited++;
      if (bus.instr_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_valid(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.instr_valid) pulses++;
    end
  endtask

  // mode 0: loop back to 5 from LAST nine times; mode 1: random in-range jumps.
  task automatic free_run(input int mode, input int first_wait);
    int exp_pc = 0;
    int loops = 0;
    int n = 0;
    int w;
    int last_cyc = -1;
    int stray = 0;
    bit seen;
    bit done = 1'b0;
    bit j;
    logic [7:0] t;
    while (!done) begin
      wait_valid(4 * TD, seen, w);
      chk("issue_seen", {63'd0, seen}, 64'd1);
      if (!seen) return;
      if (n == 0 && first_wait >= 0) chk("issue_latency", 64'(w), 64'(first_wait));
      chk("issue_pc", 64'(bus.pc), 64'(exp_pc));
      chk("issue_word", 64'(word_out()), 64'(prog[exp_pc]));
      if (last_cyc >= 0) chk("issue_period", 64'(cyc - last_cyc), 64'(TD + 2));
      last_cyc = cyc;
      j = 1'b0;
      t = 8'd0;
      if (mode == 0) begin
        if (exp_pc == int'(LAST) && loops < 9) begin
          j = 1'b1;
          t = 8'd5;
          loops++;
        end
      end else if (n < 20 && $urandom_range(99) < 30) begin
        j = 1'b1;
        t = 8'($urandom_range(int'(LAST)));
      end
      bus.jump = j;
      bus.jump_target = t;
      bus.step = 1'($urandom_range(1));
      n++;
      if (j) exp_pc = int'(t);
      else if (exp_pc == int'(LAST)) done = 1'b1;
      else exp_pc++;
    end
    repeat (TD) @(negedge clk);
    chk("halt_flag", {63'd0, bus.halted}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      if (bus.instr_valid || bus.mem_rd) stray++;
      @(negedge clk);
    end
    chk("halt_quiet", 64'(stray), 64'd0);
    chk("halt_pc", 64'(bus.pc), 64'(LAST));
    chk("halt_word", 64'(word_out()), 64'(prog[LAST]));
  endtask

  initial begin
    bit   seen;
    int   w;
    int   pulses;
    int   exp_pc;
    logic [7:0] bad_t;

    for (int i = 0; i < 256; i++) prog[i] = $urandom;
    prog[0] = 32'h0005_0000;
    prog[1] = 32'h0009_0006;
    rst = 1'b1;
    bus.run = 1'b1;
    bus.single_step = 1'b0;
    bus.step = 1'b0;
    bus.jump = 1'b0;
    bus.jump_target = 8'd0;

    // Reset with run held high, then first fetch/issue timing.
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({bus.mem_rd, bus.instr_valid, bus.halted, bus.fault, bus.pc,
                              bus.oper, bus.addr1, bus.addr2, bus.addr3}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_fetch", 64'({bus.mem_rd, bus.mem_addr}), 64'({1'b1, 8'd0}));
    @(negedge clk);
    chk("wait_no_rd", 64'({bus.mem_rd, bus.instr_valid}), 64'd0);
    free_run(0, 1);

    // Leave HALT via run=0, then random jump program.
    bus.run = 1'b0;
    @(negedge clk);
    chk("idle_clear", 64'({bus.halted, bus.pc, word_out()}), 64'd0);
    bus.run = 1'b1;
    free_run(1, 3);

    // Out-of-range jump target faults and halts in place.
    bus.run = 1'b0;
    @(negedge clk);
    bus.run = 1'b1;
    wait_valid(4 * TD, seen, w);
    chk("fault_issue", 64'({seen, bus.pc}), 64'({1'b1, 8'd0}));
    bad_t = 8'($urandom_range(255, int'(LAST) + 1));
    bus.jump = 1'b1;
    bus.jump_target = bad_t;
    repeat (TD) @(negedge clk);
    chk("fault_halt", 64'({bus.halted, bus.fault, bus.pc}), 64'({1'b1, 1'b1, 8'd0}));
    bus.run = 1'b0;
    bus.jump = 1'b0;
    bus.step = 1'b0;
    @(negedge clk);
    chk("fault_sticky", 64'({bus.halted, bus.fault}), 64'({1'b0, 1'b1}));

    // Single-step mode.
    bus.single_step = 1'b1;
    bus.run = 1'b1;
    wait_valid(4 * TD, seen, w);
    chk("step_first_issue", 64'({seen, bus.pc}), 64'({1'b1, 8'd0}));
    count_valid(20, pulses);
    chk("step_idle_hold", 64'({pulses[7:0], bus.pc}), 64'({8'd0, 8'd0}));
    bus.step = 1'b1;
    count_valid(20, pulses);
    chk("step_single_press", 64'({pulses[7:0], bus.pc}), 64'({8'd1, 8'd1}));
    bus.step = 1'b0;
    exp_pc = 1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bus.step = 1'b1;
      repeat ($urandom_range(3, 1)) @(negedge clk);
      bus.step = 1'b0;
      repeat ($urandom_range(6, 4)) @(negedge clk);
      exp_pc++;
    end
    chk("step_presses_pc", 64'(bus.pc), 64'(exp_pc));
    chk("step_presses_word", 64'(word_out()), 64'(prog[exp_pc]));

    // A press arriving during WAIT is dropped even when held into EXEC.
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    chk("step_fetch", 64'({bus.mem_rd, bus.mem_addr}), 64'({1'b1, 8'(exp_pc + 1)}));
    @(negedge clk);
    bus.step = 1'b1;
    count_valid(10, pulses);
    exp_pc++;
    chk("step_dropped", 64'({pulses[7:0], bus.pc}), 64'({8'd1, 8'(exp_pc)}));

    // Drop run during WAIT, then refetch from index 0.
    bus.step = 1'b0;
    @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    chk("drop_fetch", 64'({bus.mem_rd, bus.mem_addr}), 64'({1'b1, 8'(exp_pc + 1)}));
    bus.step = 1'b0;
    @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
    chk("drop_idle", 64'({bus.instr_valid, bus.mem_rd, bus.halted, bus.fault, bus.pc, word_out()}),
        64'({1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 32'd0}));
    count_valid(3, pulses);
    chk("drop_no_issue", 64'(pulses), 64'd0);
    bus.run = 1'b1;
    bus.single_step = 1'b0;
    @(negedge clk);
    chk("refetch", 64'({bus.mem_rd, bus.mem_addr}), 64'({1'b1, 8'd0}));
    wait_valid(4 * TD, seen, w);
    chk("refetch_issue", 64'({seen, bus.pc, word_out()}), 64'({1'b1, 8'd0, prog[0]}));

    // Only reset clears fault.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("final_reset", 64'({bus.mem_rd, bus.instr_valid, bus.halted, bus.fault, bus.pc, word_out()}),
        64'd0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
